// File: rtl/mul_pp_accum.sv
`default_nettype none
// ============================================================================
// Module      : mul_pp_accum
// Description : Accumulates sixteen 8x8-bit partial products into a 64-bit
//               unsigned 32x32 product using valid/ready on both sides.
//               Default build adds one weighted row of four slices per cycle,
//               so the result is ready four edges after the input handshake.
//               Define MUL_PP_ACCUM_SINGLE_CYCLE_EN to sum all sixteen slices
//               in a single ACCUM cycle instead.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_pp_accum (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] pp_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [63:0]  product,
    output logic         out_valid,
    input  logic         out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] c_LAST_ROW = 2'd3;

    state_t         r_state;
    state_t         w_state_next;
    logic [255:0]   r_pp;
    logic [63:0]    r_acc;
    logic [1:0]     r_row;
    logic [63:0]    w_rows [4];
    logic [63:0]    w_total;
    logic           w_accept;

    // Weighted row sums: row i holds slices 4i..4i+3, slice (i,j) scaled by 2^(8(i+j)).
    always_comb begin
        w_total = '0;
        for (int i = 0; i < 4; i++) begin
            w_rows[i] = '0;
            for (int j = 0; j < 4; j++) begin
                w_rows[i] = w_rows[i] + (64'(r_pp[16*(4*i+j) +: 16]) << (8*(i+j)));
            end
            w_total = w_total + w_rows[i];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs; DONE passes out_ready through to
    // in_ready so a new operand can be taken on the same edge the result leaves.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = ACCUM;
                end
            end
            ACCUM: begin
`ifdef MUL_PP_ACCUM_SINGLE_CYCLE_EN
                w_state_next = DONE;
`else
                if (r_row == c_LAST_ROW) begin
                    w_state_next = DONE;
                end
`endif
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    w_state_next = in_valid ? ACCUM : IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_accept = in_valid & in_ready;

    // Operand capture and accumulation; the captured copy isolates the
    // in-flight operation from later changes on pp_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pp  <= '0;
            r_acc <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            r_pp  <= pp_in;
            r_acc <= '0;
            r_row <= '0;
        end else if (r_state == ACCUM) begin
`ifdef MUL_PP_ACCUM_SINGLE_CYCLE_EN
            r_acc <= w_total;
`else
            r_acc <= r_acc + w_rows[r_row];
            if (r_row != c_LAST_ROW) begin
                r_row <= r_row + 2'd1;
            end
`endif
        end
    end

    assign product = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_mul_pp_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_pp_accum
// Description : Self-checking bench for mul_pp_accum: reset, directed corner
//               values, output stall with back-to-back accept, mid-operation
//               reset, and randomized a*b stream with random valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_pp_accum;

`ifdef MUL_PP_ACCUM_SINGLE_CYCLE_EN
    localparam int c_LAT = 1;
`else
    localparam int c_LAT = 4;
`endif
    localparam int c_NUM_RAND = 1000;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] pp_in;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  product;
    logic         out_valid;
    logic         out_ready;

    int checks   = 0;
    int failures = 0;

    mul_pp_accum dut (
        .clk       (clk),
        .rst       (rst),
        .pp_in     (pp_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Partial products of a (bytes j) and b (bytes i), slice k = 4i+j.
    function automatic logic [255:0] build_pp(input logic [31:0] a, input logic [31:0] b);
        logic [255:0] pp;
        pp = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pp[16*(4*i+j) +: 16] = 16'(a[8*j +: 8]) * 16'(b[8*i +: 8]);
            end
        end
        return pp;
    endfunction

    function automatic logic [255:0] junk();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Accept one operand, scramble pp_in, wait for the result and check it.
    task automatic run_op(input logic [255:0] pp, input logic [63:0] exp, input string name);
        int cnt;
        in_valid  = 1'b1;
        pp_in     = pp;
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
        end
        tick();
        in_valid = 1'b0;
        pp_in    = junk();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s accum handshake: in_ready=%b out_valid=%b want 0 0", name, in_ready, out_valid);
        end
        cnt = 1;
        while (out_valid !== 1'b1 && cnt < 20) begin
            tick();
            if (out_valid !== 1'b1) cnt++;
            pp_in = junk();
        end
        if (out_valid !== 1'b1) cnt = 99;
        checks++;
        if (cnt != c_LAT) begin
            failures++;
            $display("FAIL %s latency: got %0d edges want %0d", name, cnt, c_LAT);
        end
        checks++;
        if (product !== exp) begin
            failures++;
            $display("FAIL %s product: got %h want %h", name, product, exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s release: out_valid=%b in_ready=%b want 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pp_in     = junk();
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || product !== 64'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: out_valid=%b product=%h in_ready=%b want 0 0 1", out_valid, product, in_ready);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        run_op(256'd0, 64'h0000000000000000, "all_zero");
        run_op(256'd1, 64'h0000000000000001, "slice0_one");
        run_op({16'hFFFF, 240'd0}, 64'hFFFF000000000000, "slice15_max");
        run_op({16{16'hFE01}}, 64'hFFFFFFFE00000001, "max_square");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, a2, b2;
        logic [63:0] held;
        int cnt;
        a  = $urandom;
        b  = $urandom;
        a2 = $urandom;
        b2 = $urandom;
        in_valid  = 1'b1;
        pp_in     = build_pp(a, b);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        pp_in    = junk();
        repeat (c_LAT) tick();
        held = product;
        checks++;
        if (out_valid !== 1'b1 || held !== 64'(a) * 64'(b)) begin
            failures++;
            $display("FAIL stall_first: out_valid=%b product=%h want 1 %h", out_valid, held, 64'(a) * 64'(b));
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'(i % 2);
            pp_in    = junk();
            tick();
            checks++;
            if (out_valid !== 1'b1 || product !== held || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cycle %0d: out_valid=%b product=%h in_ready=%b want 1 %h 0",
                         i, out_valid, product, in_ready, held);
            end
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        pp_in     = build_pp(a2, b2);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_in_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pp_in     = junk();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
        end
        cnt = 1;
        while (out_valid !== 1'b1 && cnt < 20) begin
            tick();
            if (out_valid !== 1'b1) cnt++;
        end
        checks++;
        if (cnt != c_LAT || product !== 64'(a2) * 64'(b2)) begin
            failures++;
            $display("FAIL b2b_second: edges=%0d product=%h want %0d %h", cnt, product, c_LAT, 64'(a2) * 64'(b2));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        in_valid  = 1'b1;
        pp_in     = build_pp($urandom | 32'h1, $urandom | 32'h1);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || product !== 64'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid: out_valid=%b product=%h in_ready=%b want 0 0 1", out_valid, product, in_ready);
        end
        seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        out_ready = 1'b0;
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_mid_stale: got %0d out_valid cycles want 0", seen);
        end
    endtask

    task automatic test_random();
        logic [63:0] expq[$];
        logic [31:0] a, b;
        logic [255:0] pp;
        logic        have, hs_in, hs_out;
        logic [63:0] prod, exp;
        int sent, got;
        have = 1'b0;
        sent = 0;
        got  = 0;
        a = '0;
        b = '0;
        pp = '0;
        for (int cyc = 0; cyc < 40000 && got < c_NUM_RAND; cyc++) begin
            if (!have && sent < c_NUM_RAND && $urandom_range(0, 3) != 0) begin
                a    = $urandom;
                b    = $urandom;
                pp   = build_pp(a, b);
                have = 1'b1;
            end
            in_valid  = have;
            pp_in     = have ? pp : junk();
            out_ready = ($urandom_range(0, 3) != 0);
            #3;
            hs_in  = in_valid & in_ready;
            hs_out = out_valid & out_ready;
            prod   = product;
            tick();
            if (hs_out) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL rand_extra: product %h with nothing outstanding", prod);
                end else begin
                    exp = expq.pop_front();
                    if (prod !== exp) begin
                        failures++;
                        $display("FAIL rand_product #%0d: got %h want %h", got, prod, exp);
                    end
                end
                got++;
            end
            if (hs_in) begin
                expq.push_back(64'(a) * 64'(b));
                sent++;
                have = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (got != c_NUM_RAND || expq.size() != 0) begin
            failures++;
            $display("FAIL rand_count: got %0d results, %0d outstanding, want %0d and 0", got, expq.size(), c_NUM_RAND);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_pp_accum.md
MUL_PP_ACCUM -- requirements
Module: mul_pp_accum

Interface
REQ-001 SHALL have no parameters; widths fixed: 16 partial products x 16 bits in, 64-bit result out.
REQ-002 SHALL have one clock; reset is synchronous and active-high. Ports: clk, rst.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 pp_in  input  256  packed 8x8 partial products; slice k = pp_in[16k+15:16k], k = 4*i+j, product of A byte j and B byte i.
REQ-006 in_valid  input  1  pp_in valid.
REQ-007 in_ready  output  1  block can accept pp_in this cycle.
REQ-008 product  output  64  registered unsigned 32x32 result.
REQ-009 out_valid  output  1  product valid.
REQ-010 out_ready  input  1  consumer accepts product.

Function
REQ-011 SHALL weight slice k by 2^(8*(i+j)) and sum all 16 slices into a 64-bit unsigned product; no truncation, no overflow possible.
REQ-012 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-013 IDLE: in_ready=1; on in_valid&in_ready, register pp_in, clear accumulator, clear row counter, go ACCUM.
REQ-014 ACCUM: in_ready=0; each cycle add row r = sum_j(slice(4r+j)<<8j) << 8r to accumulator, increment r; after row 3 is added go DONE.
REQ-015 Latency: handshake at edge E0, rows added at E1..E4, out_valid=1 and product stable after E4.
REQ-016 DONE: out_valid=1; product and out_valid SHALL hold unchanged while out_ready=0.
REQ-017 DONE: in_ready = out_ready; on out_ready=1 with in_valid=0 go IDLE; with in_valid=1 accept new pp_in same edge and go ACCUM (zero-bubble back-to-back).
REQ-018 Input changes on pp_in while not accepted SHALL NOT affect the in-flight result.
REQ-019 Row counter SHALL be 2 bits and SHALL NOT wrap past row 3 within one operation.
REQ-020 out_valid SHALL be 0 in IDLE and ACCUM.

Reset
REQ-021 On rst=1 at a clock edge: state=IDLE, out_valid=0, product=0, accumulator=0, row counter=0, captured pp cleared.
REQ-022 Reset during ACCUM or DONE SHALL discard the in-flight operation; no out_valid pulse follows.
REQ-023 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-024 Macro MUL_PP_ACCUM_SINGLE_CYCLE_EN selects accumulation mode.
REQ-025 Undefined: 4-row sequential accumulation per REQ-014/015.
REQ-026 Defined: all 16 weighted slices summed in one ACCUM cycle; out_valid after E1; handshake, DONE and reset behaviour unchanged.

Verification
REQ-027 all slices 0x0000, accept -> product=0x0000000000000000, out_valid after E4 (E1 with macro).
REQ-028 slice 0=0x0001, others 0 -> 0x0000000000000001; slice 15=0xFFFF only -> 0xFFFF000000000000.
REQ-029 all 16 slices 0xFE01 (0xFFFFFFFF squared) -> 0xFFFFFFFE00000001.
REQ-030 out_ready=0 for 10 cycles in DONE -> product/out_valid constant, in_ready=0; then out_ready=1 with in_valid=1 -> new op accepted same edge, next result after 4 more edges.
REQ-031 rst=1 asserted at 2nd ACCUM cycle -> next cycle IDLE, out_valid=0, product=0, in_ready=1; no stale result emitted.
REQ-032 random 32-bit a,b (>=1000 pairs), pp_in built from byte products, random valid/ready stalls -> every product equals a*b, in order, none dropped or duplicated.
